// File: rtl/quad_gen_pkg.sv
// quad_gen_pkg: shared definitions for the quadrature encoder signal generator.
//   - FSM state encoding (idle / run)
//   - Gray-coded A/B phase constants and the one-step phase advance function
//   - Bounce-emulation LFSR seed, tap mask and step function
//   - Minimum latched period for which bounce emulation is applied
// Phases are packed as {a, b}.
package quad_gen_pkg;

  // FSM states
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  // Quadrature phases, {a, b}
  localparam logic [1:0] PhaseA0B0 = 2'b00;
  localparam logic [1:0] PhaseA1B0 = 2'b10;
  localparam logic [1:0] PhaseA1B1 = 2'b11;
  localparam logic [1:0] PhaseA0B1 = 2'b01;

  // Bounce LFSR: x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting left.
  // Taps on bits 7, 5, 4, 3 feed the new bit 0.
  localparam logic [7:0] LfsrSeed = 8'h01;
  localparam logic [7:0] LfsrTaps = 8'hB8;

  // Shorter periods leave no room for the three-cycle new/old/new pattern.
  localparam int unsigned BounceMinPeriod = 4;

  // One Gray step. dir=1 walks 00->10->11->01->00, dir=0 walks the reverse.
  function automatic logic [1:0] phase_step(input logic [1:0] phase, input logic dir);
    logic [1:0] fwd;
    logic [1:0] rev;
    fwd = PhaseA0B0;
    rev = PhaseA0B0;
    case (phase)
      PhaseA0B0: begin
        fwd = PhaseA1B0;
        rev = PhaseA0B1;
      end
      PhaseA1B0: begin
        fwd = PhaseA1B1;
        rev = PhaseA0B0;
      end
      PhaseA1B1: begin
        fwd = PhaseA0B1;
        rev = PhaseA1B0;
      end
      PhaseA0B1: begin
        fwd = PhaseA0B0;
        rev = PhaseA1B1;
      end
      default: begin
        fwd = PhaseA0B0;
        rev = PhaseA0B0;
      end
    endcase
    return dir ? fwd : rev;
  endfunction

  // Advance the bounce LFSR by one position.
  function automatic logic [7:0] lfsr_step(input logic [7:0] lfsr);
    return {lfsr[6:0], ^(lfsr & LfsrTaps)};
  endfunction

endpackage

// File: rtl/quad_bounce.sv
// quad_bounce: contact-bounce overlay for the quadrature outputs.
// Only instantiated when QUAD_BOUNCE_EN is defined.
//
// An 8-bit LFSR advances once per emitted transition. When bit 0 of the
// advanced value is set and the command period is long enough, the phase
// output that changed shows new, old, new on the three cycles starting at
// the transition, then settles on the new value.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   step         in   a transition is being emitted on this edge
//   long_period  in   latched period allows bounce emulation
//   phase_cur    in   current registered phase {a, b}
//   phase_next   in   phase after this edge {a, b}
//   enc_a        out  registered phase A with bounce overlay
//   enc_b        out  registered phase B with bounce overlay
module quad_bounce
  import quad_gen_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       long_period,
  input  logic [1:0] phase_cur,
  input  logic [1:0] phase_next,
  output logic       enc_a,
  output logic       enc_b
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_adv;
  logic       glitch_q;
  logic [1:0] mask_q;
  logic [1:0] enc_q;

  assign lfsr_adv = lfsr_step(lfsr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q   <= LfsrSeed;
      glitch_q <= 1'b0;
      mask_q   <= 2'b00;
      enc_q    <= PhaseA0B0;
    end else begin
      // glitch_q is set for exactly one cycle after a bouncing transition,
      // flipping the changed bit back to its old value for one cycle.
      enc_q    <= phase_next ^ (glitch_q ? mask_q : 2'b00);
      glitch_q <= 1'b0;
      if (step) begin
        lfsr_q   <= lfsr_adv;
        glitch_q <= lfsr_adv[0] & long_period;
        mask_q   <= phase_next ^ phase_cur;
      end
    end
  end

  assign enc_a = enc_q[1];
  assign enc_b = enc_q[0];

endmodule

// File: rtl/quad_gen.sv
// quad_gen: quadrature encoder signal generator.
//
// Accepts a command (direction, step count, step period) and drives a
// Gray-coded A/B pair emulating a rotary encoder turned by that many edges.
// The phase persists across commands; only reset returns it to 00.
//
// After the final transition the block stays busy for one more cycle (done
// is high in that cycle), so a new command can be taken the cycle after done.
// A zero-step command never leaves idle and pulses done one cycle later.
//
// Configuration macro: QUAD_BOUNCE_EN enables contact-bounce emulation via
// quad_bounce; without it the outputs come straight from the phase register.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   cmd_valid   in   command present
//   cmd_ready   out  idle, command can be accepted
//   cmd_dir     in   1: A leads B, 0: B leads A
//   cmd_steps   in   number of transitions to emit
//   cmd_period  in   cycles between transitions (0 treated as 1)
//   abort       in   cancel the running command
//   enc_a       out  quadrature phase A
//   enc_b       out  quadrature phase B
//   busy        out  command in progress (~cmd_ready)
//   done        out  one-cycle pulse with the last transition
module quad_gen
  import quad_gen_pkg::*;
#(
  parameter int unsigned STEP_W   = 8,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [STEP_W-1:0]   cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic                enc_a,
  output logic                enc_b,
  output logic                busy,
  output logic                done
);

  logic [0:0]          state_q, state_d;
  logic                dir_q, dir_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [1:0]          phase_q, phase_d;
  logic                done_q, done_d;
  logic                zero_pend_q, zero_pend_d;

  logic [PERIOD_W-1:0] period_eff;
  logic                fire;

  assign period_eff = (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;

  // A transition is due when the counter hits 1 with steps remaining;
  // abort on the same cycle suppresses it.
  assign fire = (state_q == StRun) && (steps_q != '0) && (cnt_q == PERIOD_W'(1)) && !abort;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    steps_d     = steps_q;
    period_d    = period_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    done_d      = zero_pend_q;
    zero_pend_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          dir_d    = cmd_dir;
          steps_d  = cmd_steps;
          period_d = period_eff;
          if (cmd_steps == '0) begin
            zero_pend_d = 1'b1;
          end else begin
            cnt_d   = period_eff;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (steps_q == '0) begin
          // Trailing cycle after the final transition.
          state_d = StIdle;
        end else if (fire) begin
          phase_d = phase_step(phase_q, dir_q);
          steps_d = steps_q - STEP_W'(1);
          cnt_d   = period_q;
          if (steps_q == STEP_W'(1)) begin
            done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      dir_q       <= 1'b0;
      steps_q     <= '0;
      period_q    <= '0;
      cnt_q       <= '0;
      phase_q     <= PhaseA0B0;
      done_q      <= 1'b0;
      zero_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      steps_q     <= steps_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      done_q      <= done_d;
      zero_pend_q <= zero_pend_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = ~cmd_ready;
  assign done      = done_q;

`ifdef QUAD_BOUNCE_EN
  logic long_period;

  assign long_period = (period_q >= PERIOD_W'(BounceMinPeriod));

  quad_bounce u_bounce (
    .clk         (clk),
    .reset       (reset),
    .step        (fire),
    .long_period (long_period),
    .phase_cur   (phase_q),
    .phase_next  (phase_d),
    .enc_a       (enc_a),
    .enc_b       (enc_b)
  );
`else
  assign enc_a = phase_q[1];
  assign enc_b = phase_q[0];
`endif

endmodule

// File: tb/tb_quad_gen.sv
// tb_quad_gen: self-checking bench for quad_gen.
// The reference model describes each command by its accept cycle T, period P
// and step count N: transition k lands at T + k*P, done at T + N*P, busy
// through T + N*P. Phase is an index into the Gray table.
module tb_quad_gen;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [7:0]  cmd_steps;
  logic [15:0] cmd_period;
  logic        abort;
  logic        enc_a;
  logic        enc_b;
  logic        busy;
  logic        done;

  quad_gen dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .abort      (abort),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [1:0] gray [4];

  // Model state
  logic       m_active;
  logic       m_busy;
  int         m_t, m_p, m_n, m_base, m_idx;
  logic       m_dir;
  int         m_zero_done;
  int         m_glitch_at, m_glitch_old;
  logic [7:0] m_lfsr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int phase_after(input int k);
    if (m_dir) return (m_base + k) % 4;
    else return (m_base + 4 - (k % 4)) % 4;
  endfunction

  // Drive one cycle of inputs, advance the model to the next edge, check.
  task automatic tick(input logic r, input logic v, input logic d, input int st, input int pd,
                      input logic ab);
    int   prev_idx;
    int   k;
    int   last;
    logic exp_done;
    int   shown;
    @(negedge clk);
    reset      = r;
    cmd_valid  = v;
    cmd_dir    = d;
    cmd_steps  = st[7:0];
    cmd_period = pd[15:0];
    abort      = ab;
    @(posedge clk);
    cyc++;
    prev_idx = m_idx;
    exp_done = 1'b0;
    if (r) begin
      m_active    = 1'b0;
      m_busy      = 1'b0;
      m_idx       = 0;
      m_zero_done = -1;
      m_glitch_at = -1;
      m_lfsr      = 8'h01;
    end else begin
      last = m_t + m_n * m_p;
      if (m_busy && ab && cyc <= last) begin
        // Only transitions strictly before the abort edge happen.
        k = (cyc - 1 - m_t) / m_p;
        if (k > m_n) k = m_n;
        m_idx    = phase_after(k);
        m_active = 1'b0;
      end else if (!m_busy && v) begin
        m_t    = cyc;
        m_p    = (pd == 0) ? 1 : pd;
        m_n    = st;
        m_dir  = d;
        m_base = m_idx;
        if (st == 0) m_zero_done = cyc + 1;
        else m_active = 1'b1;
      end
      if (m_active) begin
        last = m_t + m_n * m_p;
        k = (cyc - m_t) / m_p;
        if (k > m_n) k = m_n;
        m_idx = phase_after(k);
        if (cyc == last) exp_done = 1'b1;
        if (cyc > last) m_active = 1'b0;
      end
      if (cyc == m_zero_done) exp_done = 1'b1;
`ifdef QUAD_BOUNCE_EN
      if (m_idx != prev_idx) begin
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        if (m_lfsr[0] && m_p >= 4) begin
          m_glitch_at  = cyc + 1;
          m_glitch_old = prev_idx;
        end
      end
`endif
    end
    m_busy = m_active;
    shown  = (cyc == m_glitch_at) ? m_glitch_old : m_idx;
    #1;
    check_eq("enc", 32'({enc_a, enc_b}), 32'(gray[shown]));
    check_eq("done", 32'(done), 32'(exp_done));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("ready", 32'(cmd_ready), 32'(!m_busy));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    gray[0] = 2'b00;
    gray[1] = 2'b10;
    gray[2] = 2'b11;
    gray[3] = 2'b01;
    m_active    = 1'b0;
    m_busy      = 1'b0;
    m_t         = 0;
    m_p         = 1;
    m_n         = 0;
    m_base      = 0;
    m_idx       = 0;
    m_dir       = 1'b0;
    m_zero_done = -1;
    m_glitch_at = -1;
    m_glitch_old = 0;
    m_lfsr      = 8'h01;
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_dir     = 1'b0;
    cmd_steps   = '0;
    cmd_period  = '0;
    abort       = 1'b0;

    // Reset, with a command held during reset that must not be taken.
    tick(1'b1, 1'b1, 1'b1, 4, 3, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(2);

    // dir=1, 4 steps, period 3
    tick(1'b0, 1'b1, 1'b1, 4, 3, 1'b0);
    idle(15);

    // dir=0, 2 steps, period 0 (treated as 1), then one forward step
    tick(1'b0, 1'b1, 1'b0, 2, 0, 1'b0);
    idle(3);
    tick(1'b0, 1'b1, 1'b1, 1, 0, 1'b0);
    idle(3);

    // zero steps: done next cycle, never busy
    tick(1'b0, 1'b1, 1'b1, 0, 100, 1'b0);
    idle(3);

    // long run aborted at T+12
    tick(1'b0, 1'b1, 1'b1, 200, 5, 1'b0);
    idle(11);
    tick(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    idle(3);

    // abort in idle ignored, abort with cmd_valid in idle accepted
    tick(1'b0, 1'b1, 1'b0, 3, 1, 1'b1);
    idle(5);

    // abort coinciding with a due transition
    tick(1'b0, 1'b1, 1'b1, 3, 2, 1'b0);
    idle(1);
    tick(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    idle(2);

    // back-to-back commands: new command offered every cycle
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, i[0], 2, 1, 1'b0);
    idle(2);

    // reset mid-run with cmd_valid held
    tick(1'b0, 1'b1, 1'b1, 10, 2, 1'b0);
    idle(5);
    tick(1'b1, 1'b1, 1'b1, 10, 2, 1'b0);
    idle(3);

    // bounce-relevant runs: long period, then short period
    tick(1'b0, 1'b1, 1'b1, 8, 10, 1'b0);
    idle(85);
    tick(1'b0, 1'b1, 1'b0, 8, 2, 1'b0);
    idle(20);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      tick(($urandom % 250) == 0, ($urandom % 3) == 0, 1'($urandom % 2),
           int'($urandom % 7), int'($urandom % 7), ($urandom % 30) == 0);
    end
    idle(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
